icache_responder: RTL

//  Direct-mapped instruction cache; the responder on the CPU fetch interface.

---
 rtl/icache_responder_pkg.sv | 19 +
 rtl/icache_block_array.sv | 50 +++++
 rtl/icache_responder.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/icache_responder_pkg.sv
// Shared fetch-side definitions for the instruction cache: FSM encodings, bus widths
// and a saturating counter helper used when ICACHE_STATS_EN is defined.
package icache_responder_pkg;

  localparam int WORD_W   = 32;
  localparam int BLOCK_W  = 128;
  localparam int OFFSET_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_READ = 2'd1,
    ST_UPDATE   = 2'd2
  } icache_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/icache_block_array.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
// One write port for refills, combinational read by index; only valid bits are reset.
module icache_block_array
  import icache_responder_pkg::*;
#(
  parameter int INDEX_BITS = 3,
  parameter int TAG_BITS   = 3
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] w_index,
  input  logic [TAG_BITS-1:0]   w_tag,
  input  logic [BLOCK_W-1:0]    w_block,
  input  logic [INDEX_BITS-1:0] r_index,
  output logic                  r_valid,
  output logic [TAG_BITS-1:0]   r_tag,
  output logic [BLOCK_W-1:0]    r_block
);

  localparam int SETS = 1 << INDEX_BITS;

  logic [SETS-1:0]     valid_r;
  logic [TAG_BITS-1:0] tag_r  [SETS];
  logic [BLOCK_W-1:0]  data_r [SETS];

  // Valid bits: cleared asynchronously so an in-flight refill can never survive reset
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      valid_r <= {SETS{1'b0}};
    end else if (we) begin
      valid_r[w_index] <= 1'b1;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Tag and data payload; meaningless until the matching valid bit is set
  always_ff @(posedge CLK) begin
    if (we) begin
      tag_r[w_index]  <= w_tag;
      data_r[w_index] <= w_block;
    end
  end

  assign r_valid = valid_r[r_index];
  assign r_tag   = tag_r[r_index];
  assign r_block = data_r[r_index];

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped read-only instruction cache on the cpu fetch port with block refill.
// Define ICACHE_STATS_EN to add saturating HIT_COUNT / MISS_COUNT outputs.
module icache_responder
  import icache_responder_pkg::*;
#(
  parameter int INDEX_BITS = 3,
  parameter int TAG_BITS   = 3
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic [31:0]                  PC,
  output logic [WORD_W-1:0]            INSTRUCTION,
  output logic                         BUSYWAIT,
  output logic                         MEM_READ,
  output logic [TAG_BITS+INDEX_BITS-1:0] MEM_ADDRESS,
  input  logic [BLOCK_W-1:0]           MEM_READDATA,
  input  logic                         MEM_BUSYWAIT
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]                  HIT_COUNT,
  output logic [15:0]                  MISS_COUNT
`endif
);

  localparam int ADDR_W = TAG_BITS + INDEX_BITS;

  icache_state_t         state_r;
  logic                  mem_read_r;
  logic [ADDR_W-1:0]     mem_addr_r;
  logic [OFFSET_W-1:0]   offset_s;
  logic [INDEX_BITS-1:0] index_s;
  logic [TAG_BITS-1:0]   tag_s;
  logic                  arr_valid_s;
  logic [TAG_BITS-1:0]   arr_tag_s;
  logic [BLOCK_W-1:0]    arr_block_s;
  logic                  hit_s;
  logic                  we_s;
  logic [WORD_W-1:0]     word_s;
  logic                  unused_pc_bits_s;

  assign offset_s         = PC[3:2];
  assign index_s          = PC[INDEX_BITS+3:4];
  assign tag_s            = PC[ADDR_W+3:INDEX_BITS+4];
  assign unused_pc_bits_s = ^{PC[31:ADDR_W+4], PC[1:0]};

  assign hit_s = arr_valid_s && (arr_tag_s == tag_s);
  assign we_s  = (state_r == ST_MEM_READ) && !MEM_BUSYWAIT;

  // The refill target comes from the address latched at miss time, not the live PC
  icache_block_array #(
    .INDEX_BITS(INDEX_BITS),
    .TAG_BITS  (TAG_BITS)
  ) u_array (
    .CLK    (CLK),
    .RESET  (RESET),
    .we     (we_s),
    .w_index(mem_addr_r[INDEX_BITS-1:0]),
    .w_tag  (mem_addr_r[ADDR_W-1:INDEX_BITS]),
    .w_block(MEM_READDATA),
    .r_index(index_s),
    .r_valid(arr_valid_s),
    .r_tag  (arr_tag_s),
    .r_block(arr_block_s)
  );

  // Little-endian word select within the cached block
  always_comb begin
    word_s = {WORD_W{1'b0}};
    case (offset_s)
      2'd0:    word_s = arr_block_s[31:0];
      2'd1:    word_s = arr_block_s[63:32];
      2'd2:    word_s = arr_block_s[95:64];
      2'd3:    word_s = arr_block_s[127:96];
      default: word_s = {WORD_W{1'b0}};
    endcase
  end

  // Refill FSM with registered memory-side request and address
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r    <= ST_IDLE;
      mem_read_r <= 1'b0;
      mem_addr_r <= {ADDR_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!hit_s) begin
            state_r    <= ST_MEM_READ;
            mem_read_r <= 1'b1;
            mem_addr_r <= {tag_s, index_s};
          end
        end
        ST_MEM_READ: begin
          if (!MEM_BUSYWAIT) begin
            state_r    <= ST_UPDATE;
            mem_read_r <= 1'b0;
            mem_addr_r <= {ADDR_W{1'b0}};
          end
        end
        ST_UPDATE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r    <= ST_IDLE;
          mem_read_r <= 1'b0;
          mem_addr_r <= {ADDR_W{1'b0}};
        end
      endcase
    end
  end

  // Hit path stays combinational so a hit costs no stall cycle
  assign BUSYWAIT    = RESET ? 1'b0 : ((state_r != ST_IDLE) || !hit_s);
  assign INSTRUCTION = RESET ? {WORD_W{1'b0}} : word_s;
  assign MEM_READ    = mem_read_r;
  assign MEM_ADDRESS = mem_addr_r;

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_count_r;
  logic [15:0] miss_count_r;

  // Hits counted per IDLE cycle, misses once per refill start
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hit_count_r  <= 16'h0000;
      miss_count_r <= 16'h0000;
    end else if (state_r == ST_IDLE) begin
      if (hit_s) begin
        hit_count_r <= sat_inc16(hit_count_r);
      end else begin
        miss_count_r <= sat_inc16(miss_count_r);
      end
    end
  end

  assign HIT_COUNT  = hit_count_r;
  assign MISS_COUNT = miss_count_r;
`endif

endmodule
